// File: rtl/nn_config_pkg.sv
// ============================================================================
// Module : nn_config_pkg
// Brief  : Shared element width, accumulator default and FSM state encoding
//          for the neuron MAC datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nn_config_pkg;

    localparam int DATA_WIDTH_DEF  = 64;
    localparam int PARALLELISM_DEF = 4;
    localparam int ELEM_W          = DATA_WIDTH_DEF / PARALLELISM_DEF;
    localparam int ACC_WIDTH_DEF   = 48;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    function automatic int elem_width(input int dw, input int par);
        return dw / par;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_lane.sv
// ============================================================================
// Module : dot_product_lane
// Brief  : Combinational signed dot product of two packed lines, result
//          sign-extended to the accumulator width.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dot_product_lane #(
    parameter int PARALLELISM = 4,
    parameter int ELEM_W      = 16,
    parameter int ACC_WIDTH   = 48
) (
    input  logic        [PARALLELISM*ELEM_W-1:0] a_i,
    input  logic        [PARALLELISM*ELEM_W-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0]          sum_o
);

    localparam int PROD_W = 2 * ELEM_W;

    logic signed [PROD_W-1:0] prod [PARALLELISM];

    generate
        for (genvar g = 0; g < PARALLELISM; g++) begin : g_mul
            assign prod[g] = PROD_W'($signed(a_i[g*ELEM_W +: ELEM_W]))
                           * PROD_W'($signed(b_i[g*ELEM_W +: ELEM_W]));
        end
    endgenerate

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            sum_o = sum_o + ACC_WIDTH'(prod[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/neuron_mac_seq.sv
// ============================================================================
// Module : neuron_mac_seq
// Brief  : Sequential neuron: streams activation lines, fetches matching
//          weight lines, accumulates dot products, adds bias and emits result.
//          Optional ReLU on the output when NPU_RELU_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module neuron_mac_seq
    import nn_config_pkg::*;
#(
    parameter int NUM_WEIGHT_LINES = 196,
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int PARALLELISM      = PARALLELISM_DEF,
    parameter int ADDRESS_WIDTH    = 10,
    parameter int ACC_WIDTH        = ACC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        w_ren,
    output logic [ADDRESS_WIDTH-1:0]    w_radd,
    input  logic [DATA_WIDTH-1:0]       w_data,
    input  logic signed [ACC_WIDTH-1:0] bias,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data
);

    localparam int                       EW        = elem_width(DATA_WIDTH, PARALLELISM);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_LINE = ADDRESS_WIDTH'(NUM_WEIGHT_LINES - 1);

    state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      act_q, act_d;
    logic                       mac_pend_q;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;

    logic                       accept;
    logic signed [ACC_WIDTH-1:0] lane_sum;
    logic signed [ACC_WIDTH-1:0] acc_mac;
    logic signed [ACC_WIDTH-1:0] biased;
    logic signed [ACC_WIDTH-1:0] result;

    // Gated by rst so no fetch request escapes while reset is held.
    assign in_ready  = (state_q == ST_FETCH) && !rst;
    assign accept    = in_valid && in_ready;
    assign w_ren     = accept;
    assign w_radd    = cnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    dot_product_lane #(
        .PARALLELISM (PARALLELISM),
        .ELEM_W      (EW),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_lane (
        .a_i   (act_q),
        .b_i   (w_data),
        .sum_o (lane_sum)
    );

    // Weight data lands one cycle after its request, paired with act_q.
    assign acc_mac = mac_pend_q ? (acc_q + lane_sum) : acc_q;
    assign biased  = acc_mac + bias;

`ifdef NPU_RELU_EN
    assign result = biased[ACC_WIDTH-1] ? '0 : biased;
`else
    assign result = biased;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_mac;
        act_d       = accept ? in_data : act_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_FETCH: begin
                if (accept) begin
                    if (cnt_q == LAST_LINE) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + ADDRESS_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                state_d     = ST_OUT;
                out_valid_d = 1'b1;
                out_data_d  = result;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d     = ST_FETCH;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            cnt_q       <= '0;
            act_q       <= '0;
            mac_pend_q  <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            mac_pend_q  <= accept;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
// ============================================================================
// Module : tb_neuron_mac_seq
// Brief  : Self-checking bench for neuron_mac_seq: constant-pattern table,
//          stall/hold/reset sequences, randomized neurons vs. arithmetic model,
//          and a full-length saturation-free large-value neuron.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_neuron_mac_seq;

    localparam int DW   = 64;
    localparam int P    = 4;
    localparam int EW   = DW / P;
    localparam int AW   = 10;
    localparam int ACCW = 48;
    localparam int N    = 4;
    localparam int NB   = 196;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, w_ren, out_valid, out_ready;
    logic [DW-1:0]   in_data, w_data;
    logic [AW-1:0]   w_radd;
    logic [ACCW-1:0] bias, out_data;

    logic            in_valid2, in_ready2, w_ren2, out_valid2, out_ready2;
    logic [DW-1:0]   in_data2, w_data2;
    logic [AW-1:0]   w_radd2;
    logic [ACCW-1:0] bias2, out_data2;

    logic [DW-1:0] line_buf [0:NB-1];
    logic [DW-1:0] wmem     [0:NB-1];
    logic [AW-1:0] radd_q [$];

    int nvec;
    int nerr;

    neuron_mac_seq #(
        .NUM_WEIGHT_LINES (N), .DATA_WIDTH (DW), .PARALLELISM (P),
        .ADDRESS_WIDTH (AW), .ACC_WIDTH (ACCW)
    ) dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
        .in_data (in_data), .w_ren (w_ren), .w_radd (w_radd), .w_data (w_data),
        .bias (bias), .out_valid (out_valid), .out_ready (out_ready),
        .out_data (out_data)
    );

    neuron_mac_seq #(
        .NUM_WEIGHT_LINES (NB), .DATA_WIDTH (DW), .PARALLELISM (P),
        .ADDRESS_WIDTH (AW), .ACC_WIDTH (ACCW)
    ) dut196 (
        .clk (clk), .rst (rst), .in_valid (in_valid2), .in_ready (in_ready2),
        .in_data (in_data2), .w_ren (w_ren2), .w_radd (w_radd2), .w_data (w_data2),
        .bias (bias2), .out_valid (out_valid2), .out_ready (out_ready2),
        .out_data (out_data2)
    );

    // Synchronous weight memory: one-cycle read latency.
    always @(posedge clk) begin
        if (w_ren)  w_data  <= wmem[w_radd];
        if (w_ren2) w_data2 <= wmem[w_radd2];
        if (w_ren)  radd_q.push_back(w_radd);
    end

    typedef struct {
        int     act;
        int     wt;
        longint bias;
        longint exp_raw;
    } vec_t;

    vec_t tbl [6];

    task automatic check1(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check48(input string nm, input logic [ACCW-1:0] act, input logic [ACCW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", nm, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [ACCW-1:0] relu(input logic [ACCW-1:0] x);
`ifdef NPU_RELU_EN
        return x[ACCW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Reference: plain sum of element products over n lines plus bias, wrapped to ACCW.
    function automatic logic [ACCW-1:0] model(input int n, input logic [ACCW-1:0] b);
        longint s;
        logic [63:0] s64;
        s = longint'($signed(b));
        for (int l = 0; l < n; l++) begin
            for (int e = 0; e < P; e++) begin
                s += longint'($signed(line_buf[l][e*EW +: EW])) * longint'($signed(wmem[l][e*EW +: EW]));
            end
        end
        s64 = s;
        return relu(s64[ACCW-1:0]);
    endfunction

    task automatic fill_const(input int a, input int w);
        logic [EW-1:0] av, wv;
        av = a[EW-1:0];
        wv = w[EW-1:0];
        for (int l = 0; l < NB; l++) begin
            for (int e = 0; e < P; e++) begin
                line_buf[l][e*EW +: EW] = av;
                wmem[l][e*EW +: EW]     = wv;
            end
        end
    endtask

    task automatic fill_rand();
        for (int l = 0; l < NB; l++) begin
            line_buf[l] = {$urandom, $urandom};
            wmem[l]     = {$urandom, $urandom};
        end
    endtask

    task automatic drive_lines(input int n, input int gap);
        int tries;
        for (int i = 0; i < n; i++) begin
            if (gap == 1 && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            if (gap == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = line_buf[i];
            tries    = 0;
            while (!in_ready && tries < 20) begin
                @(negedge clk);
                tries++;
            end
            if (!in_ready) begin
                nvec++;
                nerr++;
                $display("FAIL accept_timeout: line %0d not accepted within 20 cycles", i);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_radd(input string nm);
        nvec++;
        if (radd_q.size() != N) begin
            nerr++;
            $display("FAIL %s_radd_count: got %0d requests expected %0d", nm, radd_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                check48($sformatf("%s_radd%0d", nm, k), ACCW'(radd_q[k]), ACCW'(k));
            end
        end
    endtask

    task automatic do_neuron(input string nm, input int gap, input int hold, input logic [ACCW-1:0] exp);
        logic [ACCW-1:0] got;
        logic            stable;
        radd_q.delete();
        drive_lines(N, gap);
        check1({nm, "_drain_valid"}, out_valid, 1'b0);
        @(negedge clk);
        check1({nm, "_out_valid"}, out_valid, 1'b1);
        check48(nm, out_data, exp);
        got    = out_data;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== got || in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check1({nm, "_hold_stable"}, stable, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check1({nm, "_back_to_fetch"}, in_ready & ~out_valid, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACCW-1:0] e;
        logic [63:0]     r;
        longint          big;

        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        in_valid = 1'b1; in_data = '1; out_ready = 1'b0; bias = '0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0; bias2 = '0;
        for (int l = 0; l < NB; l++) begin
            line_buf[l] = '0;
            wmem[l]     = '0;
        end

        tbl[0] = '{act: 1,     wt: 2,      bias: 0,    exp_raw: 32};
        tbl[1] = '{act: -3,    wt: 5,      bias: 10,   exp_raw: -230};
        tbl[2] = '{act: -1,    wt: -1,     bias: -5,   exp_raw: 11};
        tbl[3] = '{act: 100,   wt: -200,   bias: 0,    exp_raw: -320000};
        tbl[4] = '{act: 32767, wt: -32768, bias: 1000, exp_raw: -64'sd17179343896};
        tbl[5] = '{act: 0,     wt: 12345,  bias: -7,   exp_raw: -7};

        repeat (3) @(negedge clk);
        check1("reset_out_valid", out_valid, 1'b0);
        check48("reset_out_data", out_data, '0);
        check1("reset_w_ren", w_ren, 1'b0);
        check1("reset_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check1("post_reset_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            fill_const(tbl[i].act, tbl[i].wt);
            bias = tbl[i].bias[ACCW-1:0];
            e    = tbl[i].exp_raw[ACCW-1:0];
            do_neuron($sformatf("tbl%0d", i), 0, 0, relu(e));
        end

        // Alternating in_valid must give the same result and address order.
        fill_const(1, 2);
        bias = '0;
        do_neuron("gapped", 1, 0, 48'd32);
        check_radd("gapped");

        // Consumer stall, then a second neuron must start from a cleared acc.
        fill_const(-3, 5);
        bias = 48'd10;
        e = -48'sd230;
        do_neuron("held", 0, 5, relu(e));
        fill_const(1, 2);
        bias = '0;
        do_neuron("after_hold", 0, 0, 48'd32);

        for (int t = 0; t < 8; t++) begin
            fill_rand();
            r    = {$urandom, $urandom};
            bias = r[ACCW-1:0];
            do_neuron($sformatf("rand%0d", t), 2, $urandom_range(0, 3), model(N, bias));
        end

        // Mid-neuron reset with a product still in flight.
        fill_const(7, 9);
        bias = 48'd3;
        do_neuron("pre_reset", 0, 0, 48'd1011);
        fill_rand();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = line_buf[i];
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check1("midrst_out_valid", out_valid, 1'b0);
        check48("midrst_out_data", out_data, '0);
        check1("midrst_w_ren", w_ren, 1'b0);
        check1("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        fill_rand();
        r    = {$urandom, $urandom};
        bias = r[ACCW-1:0];
        do_neuron("post_rst", 0, 0, model(N, bias));
        check_radd("post_rst");

        // Full-length neuron with maximal positive operands.
        fill_const(32767, 32767);
        bias2 = '0;
        in_valid2 = 1'b1;
        for (int i = 0; i < NB; i++) begin
            in_data2 = line_buf[i];
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        check1("big_drain_valid", out_valid2, 1'b0);
        @(negedge clk);
        check1("big_out_valid", out_valid2, 1'b1);
        big = longint'(784) * longint'(1073676289);
        check48("big_result", out_data2, big[ACCW-1:0]);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check1("big_back_to_fetch", in_ready2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/neuron_mac_seq.md
NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 SHALL have parameter NUM_WEIGHT_LINES, default 196, meaning input/weight lines per neuron.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning packed line width.
REQ-003 SHALL have parameter PARALLELISM, default 4, meaning signed elements per line; ELEM_W = DATA_WIDTH/PARALLELISM.
REQ-004 SHALL have parameter ADDRESS_WIDTH, default 10, meaning weight-memory line address width.
REQ-005 SHALL have parameter ACC_WIDTH, default 48, meaning accumulator and result width.
REQ-006 SHALL provide ports: clk  in  1  sole clock, rising edge.
REQ-007 SHALL provide: rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL provide: in_valid  in  1  input line valid; in_ready  out  1  line accepted when both high.
REQ-009 SHALL provide: in_data  in  DATA_WIDTH  PARALLELISM signed activations, element i at bits [i*ELEM_W +: ELEM_W].
REQ-010 SHALL provide: w_ren  out  1 and w_radd  out  ADDRESS_WIDTH  weight-memory read request and line address.
REQ-011 SHALL provide: w_data  in  DATA_WIDTH  weight line, same packing, valid one cycle after w_ren.
REQ-012 SHALL provide: bias  in  ACC_WIDTH  signed bias, sampled on entry to OUT.
REQ-013 SHALL provide: out_valid  out  1; out_ready  in  1; out_data  out  ACC_WIDTH  signed neuron result.

Function
REQ-014 SHALL implement states FETCH, DRAIN, OUT.
REQ-015 In FETCH, in_ready SHALL be 1; otherwise 0.
REQ-016 On accept, w_ren SHALL be 1 combinationally, w_radd = line counter, and in_data SHALL be registered.
REQ-017 One cycle after an accept, acc SHALL += sign-extended sum of PARALLELISM signed ELEM_W x ELEM_W products (w_data x registered activations).
REQ-018 Line counter SHALL increment per accept; accept at count NUM_WEIGHT_LINES-1 SHALL move to DRAIN and reset counter to 0.
REQ-019 DRAIN SHALL last exactly one cycle (final MAC) then go to OUT.
REQ-020 On entering OUT, out_data SHALL = acc + bias (ACC_WIDTH two's-complement wrap, no saturation); out_valid = 1.
REQ-021 out_valid and out_data SHALL hold stable until out_ready; on out_valid&&out_ready, acc SHALL clear and state SHALL return to FETCH the next cycle.
REQ-022 Latency: result visible 2 cycles after last accept; back-to-back neurons SHALL need no idle cycles beyond DRAIN/OUT.
REQ-023 in_valid gaps SHALL stall without corrupting acc or counter; w_ren SHALL be 0 when no accept.

Reset
REQ-024 rst SHALL force FETCH, counter 0, acc 0, out_valid 0, out_data 0, w_ren 0, and discard any in-flight product; mid-neuron reset restarts at line 0.

Configuration
REQ-025 With NPU_RELU_EN defined, out_data SHALL be 0 when acc+bias is negative; without it, out_data SHALL be raw acc+bias.

Structure
REQ-026 ELEM_W, ACC_WIDTH default, and the state enum typedef SHALL live in nn_config_pkg.
REQ-027 A sub-module dot_product_lane (PARALLELISM signed products plus adder tree, combinational) SHALL be instantiated once.

Verification
REQ-028 NUM_WEIGHT_LINES=4, all activations 1, all weights 2, bias 0 -> out_data=32, 2 cycles after last accept.
REQ-029 Activations -3, weights 5, bias 10: without NPU_RELU_EN out_data=-230; with it out_data=0.
REQ-030 in_valid toggled every other cycle -> same result as continuous input; w_radd sequence 0,1,2,3.
REQ-031 out_ready held low 5 cycles -> out_valid/out_data stable, in_ready 0; release -> FETCH, second neuron correct with acc from 0.
REQ-032 rst asserted after 2 of 4 lines -> all outputs 0 immediately; restart w_radd from 0, result unaffected by prior lines.
REQ-033 Weights 0x7FFF, activations 0x7FFF, 196 lines, bias 0 -> out_data = 784*1073676289 exactly (no overflow in 48 bits).
